ltc2308_model: RTL and testbench
================================

Name: ltc2308_model

Overview:
- Synthesizable responder for the LTC2308 serial ADC interface.
- Sits on the ADC_CONVST/ADC_SCK/ADC_SDI/ADC_SDO pins in place of the real converter, for FPGA-resident loopback and system-level simulation of the ADC interface initiator.
- Holds one 12-bit sample per channel, loaded through a host write port.
- Serially returns the sample for the channel chosen by the previous frame's config word, and captures the new config word.

Parameters:
- CONV_CYCLES, 8: clk cycles the model stays busy after a CONVST rising edge.
- SYNC_STAGES, 2: flip-flop stages in the synchronizers on ADC_CONVST, ADC_SCK and ADC_SDI.

Ports:
- clk  input  1  system clock; must run at least 8x faster than ADC_SCK.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  sample-table write strobe.
- wr_chan  input  3  channel index for the write.
- wr_data  input  12  sample value for the write.
- ADC_CONVST  input  1  conversion start, rising-edge sensitive.
- ADC_SCK  input  1  serial clock from the initiator.
- ADC_SDI  input  1  config bits from the initiator, MSB first.
- ADC_SDO  output  1  sample bits to the initiator, MSB first.
- cfg_word  output  6  last complete config word {S/D, O/S, S1, S0, UNI, SLP}.
- cfg_valid  output  1  one-cycle pulse when cfg_word updates.
- cur_chan  output  3  channel addressed by cfg_word: {S1, S0, O/S}.
- busy  output  1  high while converting.
- proto_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset values (asynchronous, reset_n low):
  - State IDLE; ADC_SDO=0; cfg_word=6'b100010 (channel 0, single-ended, unipolar); cfg_valid=0; busy=0; proto_err=0.
  - Sample table cleared to 0; bit counter=0.
- Synchronizers: CONVST, SCK and SDI each pass through SYNC_STAGES flops. Edge detect compares the last synchronized stage with one extra register.
- Edge latency: an edge on an input pin is acted on SYNC_STAGES+1 clk cycles after it occurs.
- Sample table: 8x12 registers.
  - wr_en writes wr_data to entry wr_chan on the clk edge.
  - A write to the channel being shifted out does not alter the frame in progress, because the frame uses its own latched copy.
- State IDLE:
  - CONVST rise -> CONV; busy=1; conv counter loaded with CONV_CYCLES-1.
  - SCK edges are ignored; each SCK rise raises proto_err.
- State CONV:
  - Counter decrements each cycle. At 0: latch table[cur_chan] into shift_out, drive ADC_SDO=shift_out[11], busy=0, go to SHIFT.
  - SCK rise in CONV -> proto_err pulse; the edge is otherwise ignored.
- State SHIFT:
  - On a synchronized SCK rise:
    - Shift SDI into the 12-bit shift_in LSB.
    - Increment the bit counter.
  - On an SCK fall: shift shift_out left and present the new MSB on ADC_SDO.
  - After the 12th SCK rise: go to DONE.
- State DONE (one cycle):
  - cfg_word = shift_in[11:6]; cfg_valid=1; cur_chan updated accordingly; ADC_SDO=0; return to IDLE.
  - shift_in[5:0] are don't-care and are discarded.
  - The new cfg_word selects the sample for the next conversion, matching real LTC2308 pipelining.
- CONVST rise during SHIFT (aborted frame):
  - proto_err pulse; partial config discarded; cfg_word unchanged; bit counter cleared.
  - Enter CONV immediately, using the existing cur_chan.
- CONVST rise during CONV: conversion restarts, counter reloads, proto_err pulse.
- Simultaneous wr_en and the CONV->SHIFT latch on the same channel: the latch takes the old table value.
- Reset mid-frame: returns to the reset state immediately. No cfg_valid pulse is produced for the interrupted frame.

Test Plan:
- Basic frame: reset; write table[0]=12'hA5C; CONVST pulse; 12 SCK cycles with SDI=6'b100010 then zeros -> SDO bits 1010_0101_1100; cfg_valid once; cfg_word=6'b100010; cur_chan=0.
- Channel pipelining: table[5]=12'h3F1, table[0]=12'h123. Frame 1 sends config for channel 5 (6'b111010) -> frame 1 returns 12'h123, cur_chan=5. Frame 2 returns 12'h3F1.
- Full channel sweep: random table values; 8 consecutive frames with config for chan 0..7 -> each frame returns the value for the channel configured in the previous frame; cur_chan sequence 0..7.
- Busy timing: CONVST rise -> busy asserted SYNC_STAGES+1 clk cycles later and held CONV_CYCLES cycles. SCK rise during busy -> proto_err pulse; SDO=0.
- Aborted frame: CONVST re-rises after 5 SCK cycles -> proto_err pulse; cfg_word unchanged; next full frame returns the correct data.
- Reset mid-SHIFT: reset_n low after 6 bits -> ADC_SDO=0, busy=0, cfg_word=6'b100010, table cleared, no cfg_valid pulse.

Source files
------------

// File: rtl/ltc2308_model.sv
// LTC2308 serial ADC responder: per-channel sample table, synchronized
// CONVST/SCK/SDI front end and a pipelined 6-bit config capture.
module ltc2308_model #(
    parameter int CONV_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_chan,
    input  logic [11:0] wr_data,
    input  logic        ADC_CONVST,
    input  logic        ADC_SCK,
    input  logic        ADC_SDI,
    output logic        ADC_SDO,
    output logic [5:0]  cfg_word,
    output logic        cfg_valid,
    output logic [2:0]  cur_chan,
    output logic        busy,
    output logic        proto_err
);

    localparam int CW = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] convst_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic convst_prev;
    logic sck_prev;
    logic convst_rise;
    logic sck_rise;
    logic sck_fall;
    logic sdi_bit;

    logic [CW-1:0] conv_cnt;
    logic [3:0]    bit_cnt;
    logic [11:0]   shift_out;
    logic [11:0]   shift_in;
    logic [11:0]   samples [8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_sync <= '0;
            sck_sync    <= '0;
            sdi_sync    <= '0;
            convst_prev <= 1'b0;
            sck_prev    <= 1'b0;
        end else begin
            convst_sync <= {convst_sync[SYNC_STAGES-2:0], ADC_CONVST};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], ADC_SCK};
            sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], ADC_SDI};
            convst_prev <= convst_sync[SYNC_STAGES-1];
            sck_prev    <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign convst_rise = convst_sync[SYNC_STAGES-1] & ~convst_prev;
    assign sck_rise    = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall    = ~sck_sync[SYNC_STAGES-1] & sck_prev;
    assign sdi_bit     = sdi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (convst_rise) state_next = CONV;
            end
            CONV: begin
                if (!convst_rise && conv_cnt == '0) state_next = SHIFT;
            end
            SHIFT: begin
                if (convst_rise) begin
                    state_next = CONV;
                end else if (sck_rise && bit_cnt == 4'd11) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = convst_rise ? CONV : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CONV);
        ADC_SDO   = (state == SHIFT) & shift_out[11];
        proto_err = (sck_rise & (state == IDLE || state == CONV))
                  | (convst_rise & (state == CONV || state == SHIFT));
    end

    // Writes and the CONV->SHIFT latch share an edge, so the latch sees the old entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) samples[i] <= '0;
        end else if (wr_en) begin
            samples[wr_chan] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_cnt  <= '0;
            bit_cnt   <= '0;
            shift_out <= '0;
            shift_in  <= '0;
            cfg_word  <= 6'b100010;
            cfg_valid <= 1'b0;
        end else begin
            if (convst_rise) begin
                conv_cnt <= CW'(CONV_CYCLES - 1);
            end else if (state == CONV && conv_cnt != '0) begin
                conv_cnt <= conv_cnt - 1'b1;
            end
            if (state == CONV && state_next == SHIFT) begin
                shift_out <= samples[cur_chan];
            end else if (state == SHIFT && sck_fall) begin
                shift_out <= {shift_out[10:0], 1'b0};
            end
            if (state != SHIFT || convst_rise) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 1'b1;
                shift_in <= {shift_in[10:0], sdi_bit};
            end
            cfg_valid <= (state == DONE);
            if (state == DONE) begin
                cfg_word <= shift_in[11:6];
            end
        end
    end

    assign cur_chan = {cfg_word[3], cfg_word[2], cfg_word[4]};

endmodule

// File: tb/tb_ltc2308_model.sv
// Directed bench for ltc2308_model: frames, pipelining, busy timing,
// aborted frames and mid-frame reset.
module tb_ltc2308_model;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_chan;
    logic [11:0] wr_data;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        ADC_SDO;
    logic [5:0]  cfg_word;
    logic        cfg_valid;
    logic [2:0]  cur_chan;
    logic        busy;
    logic        proto_err;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int nperr  = 0;

    ltc2308_model #(.CONV_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_chan    (wr_chan),
        .wr_data    (wr_data),
        .ADC_CONVST (ADC_CONVST),
        .ADC_SCK    (ADC_SCK),
        .ADC_SDI    (ADC_SDI),
        .ADC_SDO    (ADC_SDO),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .cur_chan   (cur_chan),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid) nvalid++;
        if (proto_err) nperr++;
    end

    function automatic logic [5:0] cfg_of(input logic [2:0] c);
        return {1'b1, c[0], c[2], c[1], 2'b10};
    endfunction

    function automatic logic [11:0] sweep_val(input logic [2:0] c);
        logic [11:0] v;
        v = 12'h111 * {9'b0, c};
        return v ^ 12'h0A5;
    endfunction

    task automatic wr(input logic [2:0] c, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_chan = c;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_convst();
        @(negedge clk);
        ADC_CONVST = 1'b1;
        repeat (4) @(negedge clk);
        ADC_CONVST = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic sck_bits(input logic [5:0] cfg, input int n,
                            output logic [11:0] got);
        logic [11:0] w;
        w = {cfg, 6'b0};
        got = '0;
        for (int i = 0; i < n; i++) begin
            ADC_SDI = w[11-i];
            repeat (HALF) @(negedge clk);
            got[11-i] = ADC_SDO;
            ADC_SCK = 1'b1;
            repeat (HALF) @(negedge clk);
            ADC_SCK = 1'b0;
        end
        ADC_SDI = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (ADC_SDO !== 1'b0) begin
            errors++;
            $display("FAIL reset_sdo got %b want 0", ADC_SDO);
        end
        checks++;
        if (cfg_word !== 6'b100010) begin
            errors++;
            $display("FAIL reset_cfg got %b want 100010", cfg_word);
        end
        checks++;
        if (cur_chan !== 3'd0) begin
            errors++;
            $display("FAIL reset_chan got %0d want 0", cur_chan);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", cfg_valid);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_perr got %b want 0", proto_err);
        end
    endtask

    task automatic test_basic();
        logic [11:0] got;
        int v0, p0;
        wr(3'd0, 12'hA5C);
        v0 = nvalid;
        p0 = nperr;
        do_convst();
        sck_bits(6'b100010, 12, got);
        checks++;
        if (got !== 12'hA5C) begin
            errors++;
            $display("FAIL basic_data got %h want a5c", got);
        end
        checks++;
        if (nvalid - v0 != 1) begin
            errors++;
            $display("FAIL basic_valid got %0d want 1", nvalid - v0);
        end
        checks++;
        if (cfg_word !== 6'b100010) begin
            errors++;
            $display("FAIL basic_cfg got %b want 100010", cfg_word);
        end
        checks++;
        if (cur_chan !== 3'd0) begin
            errors++;
            $display("FAIL basic_chan got %0d want 0", cur_chan);
        end
        checks++;
        if (nperr != p0) begin
            errors++;
            $display("FAIL basic_perr got %0d want 0", nperr - p0);
        end
    endtask

    task automatic test_pipeline();
        logic [11:0] got;
        wr(3'd5, 12'h3F1);
        wr(3'd0, 12'h123);
        do_convst();
        sck_bits(6'b111010, 12, got);
        checks++;
        if (got !== 12'h123) begin
            errors++;
            $display("FAIL pipe1_data got %h want 123", got);
        end
        checks++;
        if (cur_chan !== 3'd5) begin
            errors++;
            $display("FAIL pipe1_chan got %0d want 5", cur_chan);
        end
        do_convst();
        sck_bits(6'b100010, 12, got);
        checks++;
        if (got !== 12'h3F1) begin
            errors++;
            $display("FAIL pipe2_data got %h want 3f1", got);
        end
        checks++;
        if (cur_chan !== 3'd0) begin
            errors++;
            $display("FAIL pipe2_chan got %0d want 0", cur_chan);
        end
    endtask

    task automatic test_sweep();
        logic [11:0] got;
        logic [11:0] want;
        logic [2:0]  prev;
        for (int c = 0; c < 8; c++) wr(3'(c), sweep_val(3'(c)));
        prev = 3'd0;
        for (int c = 0; c < 8; c++) begin
            want = sweep_val(prev);
            do_convst();
            sck_bits(cfg_of(3'(c)), 12, got);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sweep_data%0d got %h want %h", c, got, want);
            end
            checks++;
            if (cur_chan !== 3'(c)) begin
                errors++;
                $display("FAIL sweep_chan%0d got %0d want %0d", c, cur_chan, c);
            end
            prev = 3'(c);
        end
    endtask

    task automatic test_busy();
        logic [11:0] got;
        int lat, len, p0;
        logic found, sdo_bad;
        p0 = nperr;
        found = 1'b0;
        sdo_bad = 1'b0;
        lat = 0;
        len = 0;
        @(negedge clk);
        ADC_CONVST = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (busy) found = 1'b1;
        end
        checks++;
        if (!found || lat != 3) begin
            errors++;
            $display("FAIL busy_latency got %0d found %b want 3", lat, found);
        end
        if (found) begin
            len = 1;
            ADC_SCK = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ADC_SDO !== 1'b0 && busy) sdo_bad = 1'b1;
                if (!busy) break;
                len++;
                if (len == 2) ADC_CONVST = 1'b0;
                if (len == 3) ADC_SCK = 1'b0;
            end
        end
        ADC_CONVST = 1'b0;
        ADC_SCK = 1'b0;
        checks++;
        if (len != 8) begin
            errors++;
            $display("FAIL busy_length got %0d want 8", len);
        end
        checks++;
        if (nperr - p0 != 1) begin
            errors++;
            $display("FAIL busy_perr got %0d want 1", nperr - p0);
        end
        checks++;
        if (sdo_bad) begin
            errors++;
            $display("FAIL busy_sdo got 1 want 0");
        end
        sck_bits(cfg_of(3'd7), 12, got);
        checks++;
        if (got !== sweep_val(3'd7)) begin
            errors++;
            $display("FAIL busy_frame got %h want %h", got, sweep_val(3'd7));
        end
    endtask

    task automatic test_abort();
        logic [11:0] got;
        int v0, p0;
        do_convst();
        sck_bits(cfg_of(3'd2), 5, got);
        checks++;
        if (got[11:7] !== sweep_val(3'd7) >> 7) begin
            errors++;
            $display("FAIL abort_partial got %h want %h", got[11:7],
                     sweep_val(3'd7) >> 7);
        end
        v0 = nvalid;
        p0 = nperr;
        do_convst();
        checks++;
        if (nperr - p0 != 1) begin
            errors++;
            $display("FAIL abort_perr got %0d want 1", nperr - p0);
        end
        checks++;
        if (nvalid != v0) begin
            errors++;
            $display("FAIL abort_valid got %0d want 0", nvalid - v0);
        end
        checks++;
        if (cfg_word !== cfg_of(3'd7)) begin
            errors++;
            $display("FAIL abort_cfg got %b want %b", cfg_word, cfg_of(3'd7));
        end
        sck_bits(cfg_of(3'd3), 12, got);
        checks++;
        if (got !== sweep_val(3'd7)) begin
            errors++;
            $display("FAIL abort_data got %h want %h", got, sweep_val(3'd7));
        end
        checks++;
        if (cur_chan !== 3'd3 || nvalid - v0 != 1) begin
            errors++;
            $display("FAIL abort_chan got %0d/%0d want 3/1", cur_chan,
                     nvalid - v0);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        int v0;
        do_convst();
        v0 = nvalid;
        sck_bits(cfg_of(3'd5), 6, got);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ADC_SDO !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_sdo_busy got %b%b want 00", ADC_SDO, busy);
        end
        checks++;
        if (cfg_word !== 6'b100010 || cur_chan !== 3'd0) begin
            errors++;
            $display("FAIL rmid_cfg got %b/%0d want 100010/0", cfg_word,
                     cur_chan);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (nvalid != v0) begin
            errors++;
            $display("FAIL rmid_valid got %0d want 0", nvalid - v0);
        end
        do_convst();
        sck_bits(cfg_of(3'd5), 12, got);
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL rmid_tab0 got %h want 000", got);
        end
        do_convst();
        sck_bits(cfg_of(3'd0), 12, got);
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL rmid_tab5 got %h want 000", got);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0;
        wr_chan = '0;
        wr_data = '0;
        ADC_CONVST = 1'b0;
        ADC_SCK = 1'b0;
        ADC_SDI = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        test_basic();
        test_pipeline();
        test_sweep();
        test_busy();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
